// File: rtl/rom_arbiter.sv
// Two-master round-robin arbiter and sequencer for the instruction ROM.
// Drives the active-low CS_/AS_ handshake, waits for Rdy_, and aborts on timeout.
module rom_arbiter #(
  parameter int unsigned ADDR_W  = 11,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req_,
  input  logic [ADDR_W-1:0] m0_addr,
  output logic [DATA_W-1:0] m0_rd_data,
  output logic              m0_rdy_,
  input  logic              m1_req_,
  input  logic [ADDR_W-1:0] m1_addr,
  output logic [DATA_W-1:0] m1_rd_data,
  output logic              m1_rdy_,
  output logic              rom_cs_,
  output logic              rom_as_,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_rd_data,
  input  logic              rom_rdy_,
  output logic              err
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  // Abort once the final allowed ACCESS cycle ends without Rdy_.
  localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

  state_t              r_state,    w_state_nxt;
  logic                r_grant,    w_grant_nxt;
  logic                r_last,     w_last_nxt;
  logic [7:0]          r_cnt,      w_cnt_nxt;
  logic                r_cs_,      w_cs_nxt;
  logic                r_as_,      w_as_nxt;
  logic [ADDR_W-1:0]   r_addr,     w_addr_nxt;
  logic [DATA_W-1:0]   r_data,     w_data_nxt;
  logic                r_rdy0_,    w_rdy0_nxt;
  logic                r_rdy1_,    w_rdy1_nxt;
  logic                r_err,      w_err_nxt;
  logic                w_win;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_grant <= 1'b0;
      r_last  <= 1'b1;
      r_cnt   <= '0;
      r_cs_   <= 1'b1;
      r_as_   <= 1'b1;
      r_addr  <= '0;
      r_data  <= '0;
      r_rdy0_ <= 1'b1;
      r_rdy1_ <= 1'b1;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cs_   <= w_cs_nxt;
      r_as_   <= w_as_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
      r_rdy0_ <= w_rdy0_nxt;
      r_rdy1_ <= w_rdy1_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // On a tie the master not served last wins; otherwise whoever is asking.
  always_comb begin
    if (!m0_req_ && !m1_req_) w_win = ~r_last;
    else                      w_win = m0_req_;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    w_cs_nxt    = r_cs_;
    w_as_nxt    = r_as_;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_rdy0_nxt  = 1'b1;
    w_rdy1_nxt  = 1'b1;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cs_nxt = 1'b1;
        w_as_nxt = 1'b1;
        if (!m0_req_ || !m1_req_) begin
          w_grant_nxt = w_win;
          w_addr_nxt  = w_win ? m1_addr : m0_addr;
          w_cs_nxt    = 1'b0;
          w_as_nxt    = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (r_cnt != 8'hFF) w_cnt_nxt = r_cnt + 8'd1;
        // Count zero marks the first ACCESS cycle, where Rdy_ may be stale.
        if (r_cnt != 8'd0 && !rom_rdy_) begin
          w_data_nxt  = rom_rd_data;
          w_cs_nxt    = 1'b1;
          w_as_nxt    = 1'b1;
          w_rdy0_nxt  = r_grant;
          w_rdy1_nxt  = ~r_grant;
          w_state_nxt = S_RESP;
        end else if (r_cnt >= LP_CNT_LAST) begin
          w_data_nxt  = '0;
          w_cs_nxt    = 1'b1;
          w_as_nxt    = 1'b1;
          w_rdy0_nxt  = r_grant;
          w_rdy1_nxt  = ~r_grant;
          w_err_nxt   = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        w_last_nxt  = r_grant;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign rom_cs_    = r_cs_;
  assign rom_as_    = r_as_;
  assign rom_addr   = r_addr;
  assign m0_rd_data = r_data;
  assign m1_rd_data = r_data;
  assign m0_rdy_    = r_rdy0_;
  assign m1_rdy_    = r_rdy1_;
  assign err        = r_err;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter with a behavioural ROM (1-cycle Rdy_,
// optional stale Rdy_ hold, or never-ready mode).
module tb_rom_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_req_ = 1'b1;
  logic [10:0] m0_addr = '0;
  logic [31:0] m0_rd_data;
  logic        m0_rdy_;
  logic        m1_req_ = 1'b1;
  logic [10:0] m1_addr = '0;
  logic [31:0] m1_rd_data;
  logic        m1_rdy_;
  logic        rom_cs_;
  logic        rom_as_;
  logic [10:0] rom_addr;
  logic [31:0] rom_rd_data = '0;
  logic        rom_rdy_ = 1'b1;
  logic        err;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  int unsigned rom_hold = 0;
  int unsigned rom_stale = 0;
  bit          rom_never = 1'b0;

  rom_arbiter #(.ADDR_W(11), .DATA_W(32), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .m0_req_(m0_req_), .m0_addr(m0_addr), .m0_rd_data(m0_rd_data), .m0_rdy_(m0_rdy_),
    .m1_req_(m1_req_), .m1_addr(m1_addr), .m1_rd_data(m1_rd_data), .m1_rdy_(m1_rdy_),
    .rom_cs_(rom_cs_), .rom_as_(rom_as_), .rom_addr(rom_addr),
    .rom_rd_data(rom_rd_data), .rom_rdy_(rom_rdy_), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [10:0] a);
    return (a == 11'h010) ? 32'hDEADBEEF : {16'hC0DE, 5'b0, a};
  endfunction

  // ROM answers one cycle after seeing both strobes low; optionally keeps
  // Rdy_ (and the old word) low for rom_hold cycles after strobes rise.
  always @(posedge clk) begin
    if (!rom_cs_ && !rom_as_) begin
      if (rom_never) begin
        rom_rdy_ <= 1'b1;
      end else begin
        rom_rdy_    <= 1'b0;
        rom_rd_data <= rom_word(rom_addr);
        rom_stale   <= rom_hold;
      end
    end else if (rom_stale != 0) begin
      rom_stale <= rom_stale - 1;
      rom_rdy_  <= 1'b0;
    end else begin
      rom_rdy_ <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    int unsigned n_low;
    bit          seen;

    // Reset values
    tick();
    check("rst_cs", 32'(rom_cs_), 32'd1);
    check("rst_as", 32'(rom_as_), 32'd1);
    check("rst_addr", 32'(rom_addr), 32'd0);
    check("rst_rdy0", 32'(m0_rdy_), 32'd1);
    check("rst_rdy1", 32'(m1_rdy_), 32'd1);
    check("rst_data", m0_rd_data, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    reset = 1'b0;
    tick();

    // Single request, 1-cycle ROM
    m0_addr = 11'h010;
    m0_req_ = 1'b0;
    tick();
    check("t1_c1_cs", 32'(rom_cs_), 32'd0);
    check("t1_c1_as", 32'(rom_as_), 32'd0);
    check("t1_c1_addr", 32'(rom_addr), 32'h010);
    tick();
    check("t1_c2_cs", 32'(rom_cs_), 32'd0);
    check("t1_c2_rdy0", 32'(m0_rdy_), 32'd1);
    tick();
    check("t1_c3_rdy0", 32'(m0_rdy_), 32'd0);
    check("t1_c3_data", m0_rd_data, 32'hDEADBEEF);
    check("t1_c3_rdy1", 32'(m1_rdy_), 32'd1);
    check("t1_c3_err", 32'(err), 32'd0);
    check("t1_c3_cs", 32'(rom_cs_), 32'd1);
    m0_req_ = 1'b1;
    tick();
    check("t1_c4_rdy0", 32'(m0_rdy_), 32'd1);

    // Simultaneous held requests alternate m0, m1, m0, m1
    do_reset();
    m0_addr = 11'h001;
    m1_addr = 11'h002;
    m0_req_ = 1'b0;
    m1_req_ = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      tick();
      check("rr_addr", 32'(rom_addr), (i % 2 == 0) ? 32'h001 : 32'h002);
      check("rr_cs", 32'(rom_cs_), 32'd0);
      tick();
      tick();
      check("rr_rdy0", 32'(m0_rdy_), (i % 2 == 0) ? 32'd0 : 32'd1);
      check("rr_rdy1", 32'(m1_rdy_), (i % 2 == 0) ? 32'd1 : 32'd0);
      check("rr_data", m0_rd_data, (i % 2 == 0) ? 32'hC0DE0001 : 32'hC0DE0002);
      if (i == 3) begin
        m0_req_ = 1'b1;
        m1_req_ = 1'b1;
      end
      tick();
      check("rr_idle_rdy", {30'd0, m0_rdy_, m1_rdy_}, 32'd3);
    end

    // Stale Rdy_ held into m1's first ACCESS cycle
    do_reset();
    rom_hold = 2;
    m0_addr = 11'h010;
    m1_addr = 11'h002;
    m0_req_ = 1'b0;
    m1_req_ = 1'b0;
    tick();
    tick();
    tick();
    check("st_rdy0", 32'(m0_rdy_), 32'd0);
    check("st_data0", m0_rd_data, 32'hDEADBEEF);
    m0_req_ = 1'b1;
    tick();
    tick();
    check("st_c5_addr", 32'(rom_addr), 32'h002);
    check("st_c5_staleRdy", 32'(rom_rdy_), 32'd0);
    tick();
    check("st_c6_cs", 32'(rom_cs_), 32'd0);
    check("st_c6_rdy1", 32'(m1_rdy_), 32'd1);
    tick();
    check("st_c7_rdy1", 32'(m1_rdy_), 32'd0);
    check("st_c7_data", m1_rd_data, 32'hC0DE0002);
    m1_req_ = 1'b1;
    rom_hold = 0;
    for (int unsigned i = 0; i < 4; i++) tick();

    // Timeout: ROM never answers
    do_reset();
    rom_never = 1'b1;
    m0_addr = 11'h003;
    m0_req_ = 1'b0;
    n_low = 0;
    seen = 1'b0;
    for (int unsigned i = 0; i < 40 && !seen; i++) begin
      tick();
      if (!m0_rdy_) seen = 1'b1;
      else if (!rom_cs_) n_low++;
    end
    check("to_seen", 32'(seen), 32'd1);
    check("to_cycles", n_low, 32'd15);
    check("to_data", m0_rd_data, 32'd0);
    check("to_err", 32'(err), 32'd1);
    check("to_rdy1", 32'(m1_rdy_), 32'd1);
    m0_req_ = 1'b1;
    tick();
    check("to_err_pulse", 32'(err), 32'd0);
    rom_never = 1'b0;
    m0_addr = 11'h004;
    m0_req_ = 1'b0;
    tick();
    tick();
    tick();
    check("to_next_rdy0", 32'(m0_rdy_), 32'd0);
    check("to_next_data", m0_rd_data, 32'hC0DE0004);
    check("to_next_err", 32'(err), 32'd0);
    m0_req_ = 1'b1;
    tick();

    // Reset mid-ACCESS
    tick();
    m0_addr = 11'h006;
    m0_req_ = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("mr_cs", 32'(rom_cs_), 32'd1);
    check("mr_as", 32'(rom_as_), 32'd1);
    check("mr_rdy", {30'd0, m0_rdy_, m1_rdy_}, 32'd3);
    tick();
    reset = 1'b0;
    m0_req_ = 1'b1;
    n_low = 0;
    for (int unsigned i = 0; i < 5; i++) begin
      tick();
      if (!m0_rdy_ || !m1_rdy_ || !rom_cs_) n_low++;
    end
    check("mr_quiet", n_low, 32'd0);
    m1_addr = 11'h007;
    m1_req_ = 1'b0;
    tick();
    tick();
    tick();
    check("mr_rdy1", 32'(m1_rdy_), 32'd0);
    check("mr_data", m1_rd_data, 32'hC0DE0007);
    m1_req_ = 1'b1;
    tick();

    // m1 address change while waiting behind m0
    do_reset();
    m0_addr = 11'h008;
    m1_addr = 11'h100;
    m0_req_ = 1'b0;
    m1_req_ = 1'b0;
    tick();
    check("ac_m0_addr", 32'(rom_addr), 32'h008);
    m1_addr = 11'h200;
    tick();
    tick();
    check("ac_rdy0", 32'(m0_rdy_), 32'd0);
    m0_req_ = 1'b1;
    tick();
    tick();
    check("ac_m1_addr", 32'(rom_addr), 32'h200);
    tick();
    tick();
    check("ac_rdy1", 32'(m1_rdy_), 32'd0);
    check("ac_data", m1_rd_data, 32'hC0DE0200);
    m1_req_ = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
